uart_tx_bridge: RTL
===================

UART_TX_BRIDGE -- requirements
Module: uart_tx_bridge

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, number of clk cycles per UART bit; legal range is 2 or more.
REQ-002 Parameter: FIFO_DEPTH, default 4, byte buffer depth; it SHALL be a power of two of 2 or more.
REQ-003 Port: clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: data_in  input  8  received byte from the I2C receiver stage, already in the clk domain.
REQ-006 Port: data_valid  input  1  data_in is valid this cycle.
REQ-007 Port: data_ready  output  1  combinational !full; the buffer can accept a byte.
REQ-008 Port: tx  output  1  UART serial line, registered, idle high.
REQ-009 Port: busy  output  1  registered; high whenever the FSM is not IDLE.
REQ-010 Port: overflow  output  1  registered one-cycle pulse when a byte is dropped.

Function
REQ-011 A write SHALL occur on the edge where data_valid && data_ready; the byte goes to the FIFO tail.
REQ-012 data_valid while full SHALL drop the byte, leave the FIFO unchanged and pulse overflow high for exactly the next cycle.
REQ-013 The FIFO SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits, with wrap-around modulo 2*FIFO_DEPTH.
REQ-014 Empty SHALL be pointers equal; full SHALL be addresses equal with wrap bits different.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: tx=1; if the FIFO is non-empty at an edge, pop the head into a shift register, go to START and drive tx=0 on that same edge.
REQ-017 Latency: a byte written into an empty FIFO with the FSM in IDLE at edge N SHALL drive tx low after edge N+1.
REQ-018 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a counter running 0..CLKS_PER_BIT-1 that resets on every bit transition.
REQ-019 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; after bit 7 go to PARITY (if enabled) or STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; at its end, if the FIFO is non-empty, pop and go directly to START (no idle cycle), else go to IDLE.
REQ-021 A simultaneous write and pop in one cycle SHALL both take effect; the count is unchanged, and the write is accepted only if data_ready was high.
REQ-022 A pop SHALL never occur on an empty FIFO; a write SHALL never occur on a full one.
REQ-023 A full frame SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-024 rst_n low SHALL immediately force: FSM=IDLE, tx=1, busy=0, overflow=0, pointers=0 (FIFO empty), bit counter=0, bit index=0.
REQ-025 Reset mid-frame SHALL abort the frame; tx returns high asynchronously, and buffered bytes are discarded.
REQ-026 FIFO storage contents need not be reset.
REQ-027 After rst_n deasserts, operation SHALL resume on the first rising clk edge.

Configuration
REQ-028 Macro UART_TX_BRIDGE_PARITY_EN defined: PARITY state inserted after DATA, sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-029 Macro UART_TX_BRIDGE_PARITY_EN undefined: no PARITY state and no parity logic; frame is 8N1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Reset then idle 50 cycles -> tx=1, busy=0, data_ready=1, overflow=0 throughout.
REQ-031 Write 0xA5 at edge N -> tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; busy=0 after 40 cycles.
REQ-032 Write 0x11,0x22,0x33 back-to-back -> three contiguous 40-cycle frames with no idle gap, and bytes in order.
REQ-033 Write 6 bytes on consecutive cycles from empty -> first byte popped on N+1; 5 accepted (4 buffered + 1 in flight), byte 6 dropped with data_ready=0 and a single overflow pulse; 5 frames sent.
REQ-034 Assert rst_n low in the middle of data bit 3 of 0xFF with 2 bytes queued -> tx=1 immediately, FIFO empty, no further frames.
REQ-035 With UART_TX_BRIDGE_PARITY_EN defined, send 0x07 -> parity bit 1 and 44-cycle frame; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_bridge.sv
// Byte FIFO feeding an 8N1 UART transmitter (8E1 when UART_TX_BRIDGE_PARITY_EN is defined).
// Bit timing is CLKS_PER_BIT clk cycles; back-to-back frames leave no idle gap.
module uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_BRIDGE_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      shift;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic            empty, full, wr_en, pop, bit_end;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign data_ready = !full;
  assign wr_en      = data_valid && !full;
  assign bit_end    = (cnt == CNT_MAX);
  // A pop is taken either from IDLE or on the last cycle of STOP, so frames chain seamlessly.
  assign pop        = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      overflow <= data_valid && full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr[AW-1:0]];
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
`ifdef UART_TX_BRIDGE_PARITY_EN
              tx    <= ^shift;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
              tx  <= shift[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_BRIDGE_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr[AW-1:0]];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
